sprite_row_renderer: RTL

//  Parametrised pixel-rate renderer for one horizontal row of identical scaled sprites (invader rows, shields, lives).

---
 rtl/sprite_row_renderer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_row_renderer.sv
// Pixel-rate renderer for one horizontal row of identical scaled sprites with a run-time loaded,
// multi-frame bitmap. Optional collision latch enabled by defining SPRITE_ROW_COLLIDE_EN.
module sprite_row_renderer #(
    parameter int NUM_SPRITES = 11,
    parameter int SPR_W       = 12,
    parameter int SPR_H       = 8,
    parameter int SCALE       = 2,
    parameter int SPACING     = 32,
    parameter int NUM_FRAMES  = 2,
    parameter int X_W         = 10,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1,
    localparam int IW = $clog2(NUM_SPRITES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   line_end,
    input  logic [X_W-1:0]         row_x,
    input  logic [FW-1:0]          frame_sel,
    input  logic [X_W-1:0]         pixel_x,
    input  logic [NUM_SPRITES-1:0] alive,
    input  logic                   bm_we,
    input  logic [FW-1:0]          bm_frame,
    input  logic [RW-1:0]          bm_row,
    input  logic [SPR_W-1:0]       bm_data,
`ifdef SPRITE_ROW_COLLIDE_EN
    input  logic                   probe,
    input  logic                   collide_clr,
    output logic                   collide_valid,
    output logic [IW-1:0]          collide_idx,
`endif
    output logic                   spr_hit,
    output logic [IW-1:0]          spr_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int XW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CMPW = X_W + $clog2(NUM_SPRITES * SPACING);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAW, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          y_q, y_d;
    logic [SW-1:0]          cy_q, cy_d;
    logic [XW-1:0]          x_q, x_d;
    logic [SW-1:0]          cx_q, cx_d;
    logic [IW-1:0]          k_q, k_d;
    logic [X_W-1:0]         row_q, row_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [NUM_SPRITES-1:0] alive_q, alive_d;
    logic                   hit_q, hit_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   done_q, done_d;

    logic [SPR_W-1:0]       bitmap_q [NUM_FRAMES][SPR_H];
    logic [SPR_W-1:0]       row_word;
    logic [SPR_W-1:0]       row_sh;
    logic [NUM_SPRITES-1:0] alive_sh;
    logic [CMPW-1:0]        target;
    logic                   at_edge;
    logic                   last_line;
    logic                   frame_ok;
    logic                   bm_in_range;
    logic                   emit;
    logic                   pix;
    logic [XW-1:0]          cur_x;
    logic [SW-1:0]          cur_cx;

    assign bm_in_range = (32'(bm_frame) < NUM_FRAMES) && (32'(bm_row) < SPR_H);
    assign frame_ok    = 32'(frame_q) < NUM_FRAMES;
    assign row_word    = bitmap_q[frame_q][y_q];
    // Wide compare so sprites placed past the right edge never alias onto the screen.
    assign target      = CMPW'(row_q) + CMPW'(k_q) * CMPW'(SPACING);
    assign at_edge     = (CMPW'(pixel_x) == target);
    assign alive_sh    = alive_q >> k_q;
    assign last_line   = (y_q == RW'(SPR_H - 1)) && (cy_q == SW'(SCALE - 1));

    always_ff @(posedge clk) begin
        if (bm_we && bm_in_range) begin
            bitmap_q[bm_frame][bm_row] <= bm_data;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cy_d    = cy_q;
        x_d     = x_q;
        cx_d    = cx_q;
        k_d     = k_q;
        row_d   = row_q;
        frame_d = frame_q;
        alive_d = alive_q;
        hit_d   = 1'b0;
        idx_d   = '0;
        done_d  = 1'b0;
        emit    = 1'b0;
        cur_x   = x_q;
        cur_cx  = cx_q;
        row_sh  = '0;
        pix     = 1'b0;

        if (start) begin
            state_d = S_WAIT;
            y_d     = '0;
            cy_d    = '0;
            x_d     = '0;
            cx_d    = '0;
            k_d     = '0;
            row_d   = row_x;
            frame_d = frame_sel;
            alive_d = alive;
        end else if (line_end && state_q != S_IDLE) begin
            alive_d = alive;
            k_d     = '0;
            x_d     = '0;
            cx_d    = '0;
            if (last_line) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                y_d     = '0;
                cy_d    = '0;
            end else begin
                state_d = S_WAIT;
                if (cy_q == SW'(SCALE - 1)) begin
                    cy_d = '0;
                    y_d  = y_q + 1'b1;
                end else begin
                    cy_d = cy_q + 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (k_q == IW'(NUM_SPRITES)) begin
                        state_d = S_HOLD;
                    end else if (at_edge) begin
                        if (alive_sh[0]) begin
                            emit   = 1'b1;
                            cur_x  = '0;
                            cur_cx = '0;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                S_DRAW:  emit = 1'b1;
                default: ;
            endcase
        end

        // Column 0 is emitted from WAIT, so both states share the same column stepping.
        if (emit) begin
            row_sh = row_word << cur_x;
            pix    = row_sh[SPR_W-1] & frame_ok;
            hit_d  = pix;
            idx_d  = pix ? (k_q + 1'b1) : '0;
            if (cur_cx == SW'(SCALE - 1)) begin
                cx_d = '0;
                if (cur_x == XW'(SPR_W - 1)) begin
                    x_d     = '0;
                    k_d     = k_q + 1'b1;
                    state_d = S_WAIT;
                end else begin
                    x_d     = cur_x + 1'b1;
                    state_d = S_DRAW;
                end
            end else begin
                cx_d    = cur_cx + 1'b1;
                x_d     = cur_x;
                state_d = S_DRAW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            cx_q    <= '0;
            k_q     <= '0;
            row_q   <= '0;
            frame_q <= '0;
            alive_q <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cy_q    <= cy_d;
            x_q     <= x_d;
            cx_q    <= cx_d;
            k_q     <= k_d;
            row_q   <= row_d;
            frame_q <= frame_d;
            alive_q <= alive_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign spr_hit = hit_q;
    assign spr_idx = idx_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

`ifdef SPRITE_ROW_COLLIDE_EN
    logic          cv_q, cv_d;
    logic [IW-1:0] ci_q, ci_d;

    always_comb begin
        cv_d = cv_q;
        ci_d = ci_q;
        if (collide_clr) begin
            cv_d = 1'b0;
            ci_d = '0;
        end else if (!cv_q && probe && hit_d) begin
            cv_d = 1'b1;
            ci_d = idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q <= 1'b0;
            ci_q <= '0;
        end else begin
            cv_q <= cv_d;
            ci_q <= ci_d;
        end
    end

    assign collide_valid = cv_q;
    assign collide_idx   = ci_q;
`endif

endmodule
